// File: rtl/wbi_master_port.sv
`default_nettype none
// ============================================================================
// Module      : wbi_master_port
// Description : Initiator end of the wbi daisy-chain. Turns a burst Wishbone
//               host request (cyc/stb/bry) into cmd valid/ready beats and
//               folds the returning res beats back into Wishbone ack/lack/err.
//               One transaction outstanding; tid = {MID, seq} tags it so that
//               stray responses are dropped and flagged on tid_err_o.
//               Optional feature macro: WBI_MST_TIMEOUT_EN (response timeout
//               of TMO cycles while waiting for res beats).
// Revision    : 1.0 - initial release
// ============================================================================
module wbi_master_port #(
  parameter int         AW  = 32,
  parameter int         DW  = 32,
  parameter int         BW  = 4,
  parameter int         BL  = 10,
  parameter logic [1:0] MID = 2'b00,
  parameter int         TMO = 1023
) (
  input  logic          mclk,
  input  logic          reset_n,
  // Wishbone host side
  input  logic          wbm_cyc_i,
  input  logic          wbm_stb_i,
  input  logic [AW-1:0] wbm_adr_i,
  input  logic          wbm_we_i,
  input  logic [DW-1:0] wbm_dat_i,
  input  logic [BW-1:0] wbm_sel_i,
  input  logic [BL-1:0] wbm_bl_i,
  input  logic          wbm_bry_i,
  output logic [DW-1:0] wbm_dat_o,
  output logic          wbm_ack_o,
  output logic          wbm_lack_o,
  output logic          wbm_err_o,
  // chain command channel
  input  logic          wbp_cmd_wrdy_i,
  output logic          wbp_cmd_wval_o,
  output logic [AW-1:0] wbp_cmd_adr_o,
  output logic          wbp_cmd_we_o,
  output logic [DW-1:0] wbp_cmd_dat_o,
  output logic [BW-1:0] wbp_cmd_sel_o,
  output logic [3:0]    wbp_cmd_tid_o,
  output logic [BL-1:0] wbp_cmd_bl_o,
  // chain response channel
  output logic          wbp_res_rrdy_o,
  input  logic          wbp_res_rval_i,
  input  logic [DW-1:0] wbp_res_dat_i,
  input  logic          wbp_res_ack_i,
  input  logic          wbp_res_lack_i,
  input  logic          wbp_res_err_i,
  input  logic [3:0]    wbp_res_tid_i,
  output logic          tid_err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RCMD  = 3'd1,
    S_WCMD  = 3'd2,
    S_RRESP = 3'd3,
    S_WRESP = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    seq, seq_nxt;
  logic [BL-1:0] beats, beats_nxt;
  logic          orphan, orphan_nxt;   // host dropped cyc during this transaction

  logic          wval_nxt, we_nxt, ack_nxt, lack_nxt, err_nxt, tid_err_nxt;
  logic [AW-1:0] adr_nxt;
  logic [DW-1:0] dat_nxt, rdat_nxt;
  logic [BW-1:0] sel_nxt;
  logic [3:0]    tid_nxt;
  logic [BL-1:0] bl_nxt;

  logic          gone, res_match, res_fire;

`ifdef WBI_MST_TIMEOUT_EN
  localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
`else
  logic          unused_tmo;
  assign unused_tmo = (TMO > 0);
`endif

  // ack from the chain is implied by rval; the per-beat ack bit carries no extra meaning here
  logic          unused_res_ack;
  assign unused_res_ack = wbp_res_ack_i;

  assign gone      = orphan | ~wbm_cyc_i;
  assign res_match = (wbp_res_tid_i == wbp_cmd_tid_o);
  assign res_fire  = wbp_res_rval_i & wbp_res_rrdy_o;

  // Response ready: throttled by the host only while a read burst is returning
  // data; stray-tid beats and orphaned transactions are always drained.
  always_comb begin
    wbp_res_rrdy_o = 1'b1;
    if (state == S_RRESP)
      wbp_res_rrdy_o = wbm_bry_i | gone | (wbp_res_rval_i & ~res_match);
  end

  // State register and all registered outputs
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      seq            <= 2'd0;
      beats          <= '0;
      orphan         <= 1'b0;
      wbp_cmd_wval_o <= 1'b0;
      wbp_cmd_adr_o  <= '0;
      wbp_cmd_we_o   <= 1'b0;
      wbp_cmd_dat_o  <= '0;
      wbp_cmd_sel_o  <= '0;
      wbp_cmd_tid_o  <= 4'd0;
      wbp_cmd_bl_o   <= '0;
      wbm_dat_o      <= '0;
      wbm_ack_o      <= 1'b0;
      wbm_lack_o     <= 1'b0;
      wbm_err_o      <= 1'b0;
      tid_err_o      <= 1'b0;
`ifdef WBI_MST_TIMEOUT_EN
      tmo_cnt        <= '0;
`endif
    end else begin
      state          <= state_nxt;
      seq            <= seq_nxt;
      beats          <= beats_nxt;
      orphan         <= orphan_nxt;
      wbp_cmd_wval_o <= wval_nxt;
      wbp_cmd_adr_o  <= adr_nxt;
      wbp_cmd_we_o   <= we_nxt;
      wbp_cmd_dat_o  <= dat_nxt;
      wbp_cmd_sel_o  <= sel_nxt;
      wbp_cmd_tid_o  <= tid_nxt;
      wbp_cmd_bl_o   <= bl_nxt;
      wbm_dat_o      <= rdat_nxt;
      wbm_ack_o      <= ack_nxt;
      wbm_lack_o     <= lack_nxt;
      wbm_err_o      <= err_nxt;
      tid_err_o      <= tid_err_nxt;
`ifdef WBI_MST_TIMEOUT_EN
      tmo_cnt        <= tmo_nxt;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    seq_nxt     = seq;
    beats_nxt   = beats;
    orphan_nxt  = orphan | ((state != S_IDLE) & ~wbm_cyc_i);
    wval_nxt    = wbp_cmd_wval_o;
    adr_nxt     = wbp_cmd_adr_o;
    we_nxt      = wbp_cmd_we_o;
    dat_nxt     = wbp_cmd_dat_o;
    sel_nxt     = wbp_cmd_sel_o;
    tid_nxt     = wbp_cmd_tid_o;
    bl_nxt      = wbp_cmd_bl_o;
    rdat_nxt    = wbm_dat_o;
    ack_nxt     = 1'b0;
    lack_nxt    = 1'b0;
    err_nxt     = 1'b0;
    tid_err_nxt = tid_err_o;
`ifdef WBI_MST_TIMEOUT_EN
    tmo_nxt     = '0;
`endif

    case (state)
      S_IDLE: begin
        orphan_nxt = 1'b0;
        if (wbp_res_rval_i) tid_err_nxt = 1'b1;
        // The cycle carrying lack/err is the host's last view of the old
        // transaction, so a still-high stb then is not a new request.
        if (wbm_cyc_i && wbm_stb_i && !wbm_lack_o && !wbm_err_o) begin
          adr_nxt   = wbm_adr_i;
          we_nxt    = wbm_we_i;
          sel_nxt   = wbm_sel_i;
          bl_nxt    = (wbm_bl_i == '0) ? BL'(1) : wbm_bl_i;
          tid_nxt   = {MID, seq};
          if (wbm_we_i) dat_nxt = wbm_dat_i;
          wval_nxt  = 1'b1;
          beats_nxt = '0;
          state_nxt = wbm_we_i ? S_WCMD : S_RCMD;
        end
      end

      S_RCMD: begin
        if (wbp_res_rval_i) tid_err_nxt = 1'b1;
        if (wbp_cmd_wval_o && wbp_cmd_wrdy_i) begin
          wval_nxt  = 1'b0;
          state_nxt = S_RRESP;
        end
      end

      S_WCMD: begin
        if (wbp_res_rval_i) tid_err_nxt = 1'b1;
        if (wbp_cmd_wval_o) begin
          if (wbp_cmd_wrdy_i) begin
            wval_nxt = 1'b0;
            if (beats == wbp_cmd_bl_o - BL'(1)) begin
              beats_nxt = '0;
              state_nxt = S_WRESP;
            end else begin
              beats_nxt = beats + BL'(1);
              ack_nxt   = ~gone;
            end
          end
        end else if (!wbm_ack_o && (gone || (wbm_stb_i && wbm_bry_i))) begin
          // wait out the ack cycle so the host has presented its next word
          wval_nxt = 1'b1;
          dat_nxt  = wbm_dat_i;
        end
      end

      S_RRESP: begin
        if (res_fire) begin
          if (res_match) begin
            rdat_nxt = wbp_res_dat_i;
            ack_nxt  = ~gone;
            lack_nxt = wbp_res_lack_i & ~gone;
            err_nxt  = wbp_res_err_i & ~gone;
            if (wbp_res_lack_i || wbp_res_err_i) begin
              seq_nxt   = seq + 2'd1;
              state_nxt = S_IDLE;
            end
          end else begin
            tid_err_nxt = 1'b1;
          end
        end
`ifdef WBI_MST_TIMEOUT_EN
        if (!(res_fire && res_match)) begin
          if (tmo_cnt == TW'(TMO - 1)) begin
            ack_nxt   = ~gone;
            lack_nxt  = ~gone;
            err_nxt   = ~gone;
            seq_nxt   = seq + 2'd1;
            state_nxt = S_IDLE;
          end else begin
            tmo_nxt = tmo_cnt + TW'(1);
          end
        end
`endif
      end

      S_WRESP: begin
        if (res_fire) begin
          if (res_match) begin
            ack_nxt   = ~gone;
            lack_nxt  = ~gone;
            err_nxt   = wbp_res_err_i & ~gone;
            seq_nxt   = seq + 2'd1;
            state_nxt = S_IDLE;
          end else begin
            tid_err_nxt = 1'b1;
          end
        end
`ifdef WBI_MST_TIMEOUT_EN
        if (!(res_fire && res_match)) begin
          if (tmo_cnt == TW'(TMO - 1)) begin
            ack_nxt   = ~gone;
            lack_nxt  = ~gone;
            err_nxt   = ~gone;
            seq_nxt   = seq + 2'd1;
            state_nxt = S_IDLE;
          end else begin
            tmo_nxt = tmo_cnt + TW'(1);
          end
        end
`endif
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wbi_master_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_wbi_master_port
// Description : Directed self-checking bench for wbi_master_port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wbi_master_port;

`ifdef WBI_MST_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 1023;
`endif

  logic        mclk = 1'b0;
  logic        reset_n;
  logic        cyc, stb, we, bry;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [9:0]  bl;
  logic [31:0] dat_o;
  logic        ack, lack, err;
  logic        wrdy, wval, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel, cmd_tid;
  logic [9:0]  cmd_bl;
  logic        rrdy, rval, res_ack, res_lack, res_err;
  logic [31:0] res_dat;
  logic [3:0]  res_tid;
  logic        tid_err;

  int checks = 0;
  int errors = 0;

  wbi_master_port #(.TMO(TB_TMO)) dut (
    .mclk(mclk), .reset_n(reset_n),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_adr_i(adr), .wbm_we_i(we),
    .wbm_dat_i(wdat), .wbm_sel_i(sel), .wbm_bl_i(bl), .wbm_bry_i(bry),
    .wbm_dat_o(dat_o), .wbm_ack_o(ack), .wbm_lack_o(lack), .wbm_err_o(err),
    .wbp_cmd_wrdy_i(wrdy), .wbp_cmd_wval_o(wval), .wbp_cmd_adr_o(cmd_adr),
    .wbp_cmd_we_o(cmd_we), .wbp_cmd_dat_o(cmd_dat), .wbp_cmd_sel_o(cmd_sel),
    .wbp_cmd_tid_o(cmd_tid), .wbp_cmd_bl_o(cmd_bl),
    .wbp_res_rrdy_o(rrdy), .wbp_res_rval_i(rval), .wbp_res_dat_i(res_dat),
    .wbp_res_ack_i(res_ack), .wbp_res_lack_i(res_lack), .wbp_res_err_i(res_err),
    .wbp_res_tid_i(res_tid), .tid_err_o(tid_err)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge mclk);
    #1;
  endtask

  // Read transaction: optional stray beat first, optional 2-cycle bry stall
  // before beat stall_at, optional host drop of cyc after the command.
  task automatic read_txn(input logic [31:0] a, input logic [9:0] b, input logic [3:0] etid,
                          input logic [9:0] ebl, input int nb, input logic [31:0] dbase,
                          input bit bogus, input int stall_at, input bit drop);
    cyc = 1; stb = 1; we = 0; adr = a; bl = b; bry = 1; wrdy = 0;
    tick;
    stb = 0;
    check("rd_wval", wval, 1);
    check("rd_tid", cmd_tid, etid);
    check("rd_bl", cmd_bl, ebl);
    check("rd_adr", cmd_adr, a);
    check("rd_we", cmd_we, 0);
    wrdy = 1;
    tick;
    wrdy = 0;
    check("rd_wval_clr", wval, 0);
    if (drop) cyc = 0;
    if (bogus) begin
      rval = 1; res_tid = etid ^ 4'h2; res_dat = 32'hDEAD_BEEF; res_lack = 1;
      #1;
      check("bogus_rrdy", rrdy, 1);
      tick;
      check("bogus_ack", ack, 0);
      check("bogus_tid_err", tid_err, 1);
      rval = 0; res_lack = 0;
    end
    for (int i = 0; i < nb; i++) begin
      rval = 1; res_tid = etid; res_dat = dbase + i; res_lack = (i == nb - 1);
      if (i == stall_at) begin
        bry = 0;
        #1;
        check("stall_rrdy", rrdy, 0);
        repeat (2) begin
          tick;
          check("stall_ack", ack, 0);
        end
        bry = 1;
      end
      tick;
      check("rd_ack", ack, !drop);
      check("rd_lack", lack, (i == nb - 1) && !drop);
      if (!drop) check("rd_dat", dat_o, dbase + i);
    end
    rval = 0; res_lack = 0; cyc = 0;
    tick;
    check("rd_idle_ack", ack, 0);
  endtask

  initial begin
    logic [31:0] wwords [4];
    int          nacc, nack, n;
    logic        prev_ack, fire, stalled;
    logic [31:0] snap_dat;

    reset_n = 0; cyc = 0; stb = 0; we = 0; bry = 0; adr = 0; wdat = 0; sel = 0; bl = 0;
    wrdy = 0; rval = 0; res_dat = 0; res_ack = 0; res_lack = 0; res_err = 0; res_tid = 0;
    repeat (2) tick;
    check("rst_wval", wval, 0);
    check("rst_ack", ack, 0);
    check("rst_lack", lack, 0);
    check("rst_err", err, 0);
    check("rst_tid_err", tid_err, 0);
    check("rst_bl", cmd_bl, 0);
    check("rst_dat", dat_o, 0);
    reset_n = 1;
    tick;

    // single read, tid 0
    read_txn(32'h0300_0010, 10'd1, 4'h0, 10'd1, 1, 32'hA5A5_1234, 0, -1, 0);
    // stray tid 3 while expecting tid 1
    read_txn(32'h0300_0020, 10'd1, 4'h1, 10'd1, 1, 32'h0000_5555, 1, -1, 0);

    // write burst of 4, tid 2, wrdy toggling
    for (int i = 0; i < 4; i++) wwords[i] = 32'h1111_0000 + i;
    cyc = 1; stb = 1; we = 1; adr = 32'h0400_0020; sel = 4'hF; bl = 10'd4; bry = 1;
    wdat = wwords[0]; wrdy = 0;
    tick;
    check("wr_wval", wval, 1);
    check("wr_tid", cmd_tid, 4'h2);
    check("wr_bl", cmd_bl, 4);
    nacc = 0; nack = 0; prev_ack = 0; n = 0;
    while (nacc < 4 && n < 80) begin
      wrdy = ~wrdy;
      #1;
      fire = wval & wrdy; stalled = wval & ~wrdy; snap_dat = cmd_dat;
      if (fire) begin
        check("wr_beat_dat", cmd_dat, wwords[nacc]);
        check("wr_beat_tid", cmd_tid, 4'h2);
        check("wr_beat_adr", cmd_adr, 32'h0400_0020);
        nacc++;
      end
      tick;
      if (stalled) begin
        check("wr_hold_wval", wval, 1);
        check("wr_hold_dat", cmd_dat, snap_dat);
      end
      if (ack) begin
        check("wr_ack_single", prev_ack, 0);
        nack++;
        if (nack < 4) wdat = wwords[nack];
      end
      prev_ack = ack;
      n++;
    end
    check("wr_beats", nacc, 4);
    check("wr_acks", nack, 3);
    wrdy = 0; stb = 0;
    rval = 1; res_tid = 4'h2; res_lack = 1; res_err = 0;
    tick;
    check("wr_final_ack", ack, 1);
    check("wr_final_lack", lack, 1);
    check("wr_final_err", err, 0);
    rval = 0; res_lack = 0; cyc = 0;
    tick;

    // read burst of 3 with a bry stall before the 2nd beat, tid 3
    read_txn(32'h0300_0040, 10'd3, 4'h3, 10'd3, 3, 32'hC0DE_0000, 0, 1, 0);

    // five back-to-back reads, tids wrap; the last uses bl=0
    for (int k = 0; k < 5; k++)
      read_txn(32'h0300_0100 + 32'(k * 4), (k == 4) ? 10'd0 : 10'd1, 4'(k % 4), 10'd1, 1,
               32'h7700_0000 + k, 0, -1, 0);

    // host abandons a read: response consumed, no ack, tid 1
    read_txn(32'h0300_0200, 10'd1, 4'h1, 10'd1, 1, 32'h0BAD_0000, 0, -1, 1);

`ifdef WBI_MST_TIMEOUT_EN
    // no response: timeout completes with err+lack after TMO cycles, tid 2
    cyc = 1; stb = 1; we = 0; adr = 32'h0300_0300; bl = 10'd1; bry = 1;
    tick;
    stb = 0; wrdy = 1;
    tick;
    wrdy = 0; n = 0;
    while (!lack && n < 40) begin
      tick;
      n++;
    end
    check("tmo_cycles", n, TB_TMO);
    check("tmo_ack", ack, 1);
    check("tmo_err", err, 1);
    cyc = 0;
    tick;
`endif

    // reset in the middle of a write burst
    cyc = 1; stb = 1; we = 1; adr = 32'h0500_0000; bl = 10'd4; wdat = 32'h2222_0000; wrdy = 1;
    tick;
    tick;
    check("rst_pre_ack", ack, 1);
    reset_n = 0;
    tick;
    check("mid_rst_wval", wval, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_lack", lack, 0);
    check("mid_rst_tid", cmd_tid, 0);
    check("mid_rst_adr", cmd_adr, 0);
    check("mid_rst_bl", cmd_bl, 0);
    check("mid_rst_cmd_dat", cmd_dat, 0);
    check("mid_rst_tid_err", tid_err, 0);
    reset_n = 1; cyc = 0; stb = 0; wrdy = 0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
